pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage datapath: the single owner of stall, flush and bubble decisions for the IF/ID, ID/EX and EX/MEM registers. Resolves load-use hazards against the instruction in ID, squashes the fetched instruction on taken branches and jumps, and freezes the pipe during multi-cycle memory accesses. Handles system calls by draining the back end into a halted state until released.

## Interface
- DrainDepth, 3: cycles needed to retire everything downstream of ID after a syscall (≥1).
- iClk  in  1  pipeline clock.
- nRst  in  1  reset; one clock; reset is asynchronous and active-low.
- iEn  in  1  global enable; low freezes FSM and counters.
- iIdRs1Addr, iIdRs2Addr  in  RegAddrWidth  source registers of the ID instruction (0 when unused).
- iExRdAddr  in  RegAddrWidth  destination of the EX instruction.
- iExValid, iExIsLoad  in  1  EX instruction valid / is a load.
- iBrTrue, iJump  in  1  taken branch / JAL|JALR resolved in ID.
- iSysCall  in  1  ID holds ECALL/EBREAK.
- iMemReq, iMemAck  in  1  MEM access in progress / completes this cycle.
- iResume  in  1  external trap handler release.
- oStallIF, oStallID, oStallEX, oStallMem  out  1  hold the corresponding pipeline register.
- oFlushIF  out  1  load a bubble into IF/ID.
- oBubbleEX  out  1  load a bubble into ID/EX.
- oHalted  out  1  FSM in HALT.
- oState  out  2  current state code.

## Operation
- States: RUN=0, MEM_WAIT=1, DRAIN=2, HALT=3. Drain counter width $clog2(DrainDepth+1).
- memstall = iMemReq & ~iMemAck (RUN, DRAIN) or ~iMemAck (MEM_WAIT).
- loaduse = iExValid & iExIsLoad & iExRdAddr≠0 & (iExRdAddr==iIdRs1Addr | iExRdAddr==iIdRs2Addr).
- Priority in RUN: memstall > loaduse > syscall > branch/jump.
- RUN, memstall: all four stalls =1; next MEM_WAIT.
- MEM_WAIT: all four stalls =1 until iMemAck; ack cycle stalls =0, next RUN.
- RUN, loaduse: oStallIF=oStallID=1, oBubbleEX=1, one cycle; branch/syscall in ID ignored that cycle (re-evaluated next cycle).
- RUN, iSysCall: syscall passes to EX; oStallIF=1, oFlushIF=1; counter←DrainDepth; next DRAIN.
- DRAIN: oStallIF=1, oFlushIF=1, oBubbleEX=1; counter decrements each cycle without memstall; memstall in DRAIN asserts all stalls and holds counter; counter==1 and no memstall → HALT.
- HALT: oStallIF=oStallID=1, oBubbleEX=1, oHalted=1; iResume → RUN next cycle.
- RUN, iBrTrue|iJump, no higher-priority event: oFlushIF=1 one cycle.
- iEn=0: all four stalls =1, flush/bubble =0, state/counter held.

## Timing
- Stall/flush/bubble outputs are combinational from state and inputs, same cycle; state changes on iClk rising edge.
- While nRst=0: state RUN, counter 0, all stall/flush/bubble outputs 0, oHalted=0, oState=0. Reset mid-DRAIN/HALT/MEM_WAIT returns to RUN.
- iMemReq with iMemAck same cycle: zero stall.
- Syscall to oHalted: DrainDepth+1 cycles absent memory stalls.
- iResume ignored outside HALT; iSysCall ignored outside RUN.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs oStallCycles, oFlushCount (32 bits each, wrap at 2^32). oStallCycles increments every cycle oStallID=1 with iEn=1; oFlushCount increments each oFlushIF pulse in RUN. Both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- pipeline_types: pipe_ctrl_state_t enum (2 bits, codes above) and pipe_stall_t struct {if, id, ex, mem}.
- Sub-module hazard_detect: combinational loaduse comparator, reusable by forwarding logic.

## Test plan
- EX lw x5, ID add x6,x5,x7 → one cycle oStallIF=oStallID=oBubbleEX=1; next cycle all 0.
- EX lw x0, ID reads x0 → no stall.
- iMemReq=1, iMemAck low 3 cycles → all stalls 1 for 3 cycles, oState=1, released on ack cycle; req+ack same cycle → no stall.
- iBrTrue=1 in RUN → oFlushIF=1 one cycle; iBrTrue with loaduse → stall only, no flush.
- iSysCall, DrainDepth=3 → DRAIN 3 cycles, oHalted=1 on 4th; mem stall mid-drain extends by stall length; iResume → RUN.
- nRst asserted in HALT → oHalted=0, oState=0 immediately; PIPE_CTRL_PERF_EN: 2 load-use stalls + 1 branch → oStallCycles=2, oFlushCount=1.

Source files
------------

// File: rtl/pipeline_types.sv
// Shared types for the pipeline sequencing controller:
// FSM state codes and the per-register stall bundle.
package pipeline_types;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALT     = 2'd3
   } pipe_ctrl_state_t;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
   } pipe_stall_t;

   localparam pipe_stall_t STALL_NONE = pipe_stall_t'(4'b0000);
   localparam pipe_stall_t STALL_ALL  = pipe_stall_t'(4'b1111);
   localparam pipe_stall_t STALL_FE   = pipe_stall_t'(4'b1100);
   localparam pipe_stall_t STALL_IF   = pipe_stall_t'(4'b1000);

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX load writing a register the ID
// instruction reads. x0 never creates a dependency.
module hazard_detect #(
   parameter int RegAddrWidth = 5
) (
   input  logic [RegAddrWidth-1:0] id_rs1_addr,
   input  logic [RegAddrWidth-1:0] id_rs2_addr,
   input  logic [RegAddrWidth-1:0] ex_rd_addr,
   input  logic                    ex_valid,
   input  logic                    ex_is_load,
   output logic                    load_use
);

   logic rd_nz;
   logic rd_hit;

   assign rd_nz  = |ex_rd_addr;
   assign rd_hit = (ex_rd_addr == id_rs1_addr) |
                   (ex_rd_addr == id_rs2_addr);

   assign load_use = ex_valid & ex_is_load & rd_nz & rd_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/bubble owner for the five-stage pipe.
// Optional perf counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipeline_types::*;
#(
   parameter int DrainDepth   = 3,
   parameter int RegAddrWidth = 5
) (
   input  logic                    iClk,
   input  logic                    nRst,
   input  logic                    iEn,
   input  logic [RegAddrWidth-1:0] iIdRs1Addr,
   input  logic [RegAddrWidth-1:0] iIdRs2Addr,
   input  logic [RegAddrWidth-1:0] iExRdAddr,
   input  logic                    iExValid,
   input  logic                    iExIsLoad,
   input  logic                    iBrTrue,
   input  logic                    iJump,
   input  logic                    iSysCall,
   input  logic                    iMemReq,
   input  logic                    iMemAck,
   input  logic                    iResume,
   output logic                    oStallIF,
   output logic                    oStallID,
   output logic                    oStallEX,
   output logic                    oStallMem,
   output logic                    oFlushIF,
   output logic                    oBubbleEX,
   output logic                    oHalted,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0]             oStallCycles,
   output logic [31:0]             oFlushCount,
`endif
   output logic [1:0]              oState
);

   localparam int CW = $clog2(DrainDepth + 1);

   pipe_ctrl_state_t state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   pipe_stall_t      stall;
   logic             flush, bubble;
   logic             load_use, req_stall;

   hazard_detect #(.RegAddrWidth(RegAddrWidth)) u_hazard (
      .id_rs1_addr (iIdRs1Addr),
      .id_rs2_addr (iIdRs2Addr),
      .ex_rd_addr  (iExRdAddr),
      .ex_valid    (iExValid),
      .ex_is_load  (iExIsLoad),
      .load_use    (load_use)
   );

   assign req_stall = iMemReq & ~iMemAck;

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      stall   = STALL_NONE;
      flush   = 1'b0;
      bubble  = 1'b0;
      if (!iEn) begin
         stall = STALL_ALL;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (req_stall) begin
                  stall   = STALL_ALL;
                  state_n = ST_MEM_WAIT;
               end else if (load_use) begin
                  stall  = STALL_FE;
                  bubble = 1'b1;
               end else if (iSysCall) begin
                  stall   = STALL_IF;
                  flush   = 1'b1;
                  cnt_n   = CW'(DrainDepth);
                  state_n = ST_DRAIN;
               end else if (iBrTrue | iJump) begin
                  flush = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               if (!iMemAck) stall = STALL_ALL;
               else          state_n = ST_RUN;
            end
            ST_DRAIN: begin
               // A memory stall freezes the drain without losing count.
               if (req_stall) begin
                  stall = STALL_ALL;
               end else begin
                  stall  = STALL_IF;
                  flush  = 1'b1;
                  bubble = 1'b1;
                  cnt_n  = cnt - CW'(1);
                  if (cnt == CW'(1)) state_n = ST_HALT;
               end
            end
            ST_HALT: begin
               stall  = STALL_FE;
               bubble = 1'b1;
               if (iResume) state_n = ST_RUN;
            end
         endcase
      end
   end

   assign oStallIF  = nRst & stall.stall_if;
   assign oStallID  = nRst & stall.stall_id;
   assign oStallEX  = nRst & stall.stall_ex;
   assign oStallMem = nRst & stall.stall_mem;
   assign oFlushIF  = nRst & flush;
   assign oBubbleEX = nRst & bubble;
   assign oHalted   = (state == ST_HALT);
   assign oState    = state;

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         oStallCycles <= '0;
         oFlushCount  <= '0;
      end else begin
         if (iEn && oStallID)
            oStallCycles <= oStallCycles + 32'd1;
         if (oFlushIF && state == ST_RUN)
            oFlushCount <= oFlushCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed steps then
// random traffic against a behavioural reference model.
module tb_pipe_ctrl;

   localparam int D  = 3;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          nRst, en;
   logic [AW-1:0] rs1, rs2, rd;
   logic          exv, exld, br, jmp, sys, mreq, mack, res;
   logic          s_if, s_id, s_ex, s_mem, fl, bub, hlt;
   logic [1:0]    st;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]   sc, fc;
`endif

   int vectors = 0;
   int fails   = 0;

   // reference model state
   int m_state = 0;
   int m_left  = 0;
   longint m_sc = 0;
   longint m_fc = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.DrainDepth(D), .RegAddrWidth(AW)) dut (
      .iClk       (clk),
      .nRst       (nRst),
      .iEn        (en),
      .iIdRs1Addr (rs1),
      .iIdRs2Addr (rs2),
      .iExRdAddr  (rd),
      .iExValid   (exv),
      .iExIsLoad  (exld),
      .iBrTrue    (br),
      .iJump      (jmp),
      .iSysCall   (sys),
      .iMemReq    (mreq),
      .iMemAck    (mack),
      .iResume    (res),
      .oStallIF   (s_if),
      .oStallID   (s_id),
      .oStallEX   (s_ex),
      .oStallMem  (s_mem),
      .oFlushIF   (fl),
      .oBubbleEX  (bub),
      .oHalted    (hlt),
`ifdef PIPE_CTRL_PERF_EN
      .oStallCycles (sc),
      .oFlushCount  (fc),
`endif
      .oState     (st)
   );

   // expected {stallIF,ID,EX,MEM, flush, bubble, halted, state}
   function automatic logic [8:0] expect_out();
      logic [3:0] stl = 4'b0000;
      logic f = 0, b = 0, lu, ms;
      if (!nRst) return 9'd0;
      ms = mreq && !mack;
      lu = exv && exld && rd != 0 && (rd == rs1 || rd == rs2);
      if (!en) stl = 4'b1111;
      else if (m_state == 0) begin
         if (ms) stl = 4'b1111;
         else if (lu) begin stl = 4'b1100; b = 1; end
         else if (sys) begin stl = 4'b1000; f = 1; end
         else if (br || jmp) f = 1;
      end else if (m_state == 1) begin
         if (!mack) stl = 4'b1111;
      end else if (m_state == 2) begin
         if (ms) stl = 4'b1111;
         else begin stl = 4'b1000; f = 1; b = 1; end
      end else begin
         stl = 4'b1100; b = 1;
      end
      return {stl, f, b, logic'(m_state == 3), 2'(m_state)};
   endfunction

   function automatic void model_clock();
      logic [8:0] e = expect_out();
      logic ms, lu;
      if (!nRst) return;
      if (en && e[7]) m_sc++;
      if (e[4] && m_state == 0) m_fc++;
      if (!en) return;
      ms = mreq && !mack;
      lu = exv && exld && rd != 0 && (rd == rs1 || rd == rs2);
      case (m_state)
         0: if (ms) m_state = 1;
            else if (!lu && sys) begin m_state = 2; m_left = D; end
         1: if (mack) m_state = 0;
         2: if (!ms) begin
               if (m_left == 1) m_state = 3;
               m_left--;
            end
         default: if (res) m_state = 0;
      endcase
   endfunction

   task automatic check(input string tag);
      logic [8:0] obs;
      logic [8:0] exp;
      if (!nRst) begin
         m_state = 0; m_left = 0; m_sc = 0; m_fc = 0;
      end
      #1;
      obs = {s_if, s_id, s_ex, s_mem, fl, bub, hlt, st};
      exp = expect_out();
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
`ifdef PIPE_CTRL_PERF_EN
      vectors++;
      assert (sc === 32'(m_sc) && fc === 32'(m_fc)) else begin
         fails++;
         $error("FAIL %s perf: observed %0d/%0d expected %0d/%0d",
                tag, sc, fc, 32'(m_sc), 32'(m_fc));
      end
`endif
   endtask

   task automatic step(input string tag);
      check(tag);
      model_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1; rs1 = 0; rs2 = 0; rd = 0; exv = 0; exld = 0;
      br = 0; jmp = 0; sys = 0; mreq = 0; mack = 0; res = 0;
   endtask

   task automatic loaduse_x5();
      exv = 1; exld = 1; rd = 5; rs1 = 5; rs2 = 7;
   endtask

   initial begin
      idle();
      nRst = 0;
      mreq = 1; sys = 1;
      #2 check("reset_outputs");
      @(posedge clk); #1;
      nRst = 1; idle();
      step("idle");

      loaduse_x5();
      step("loaduse_x5");
      idle();
      step("after_loaduse");
      exv = 1; exld = 1; rd = 0; rs1 = 0; rs2 = 0;
      step("load_x0");
      idle();

      mreq = 1;
      step("mem_req");
      step("mem_wait1");
      step("mem_wait2");
      mack = 1;
      step("mem_ack");
      step("req_ack_same");
      idle();

      br = 1;
      step("branch");
      loaduse_x5();
      step("branch_loaduse");
      idle(); jmp = 1;
      step("jump");
      idle();

      sys = 1;
      step("syscall");
      sys = 0;
      step("drain1");
      step("drain2");
      step("drain3");
      step("halt1");
      sys = 1; step("halt_syscall_ignored");
      sys = 0; res = 1;
      step("halt_resume");
      res = 0;
      step("run_after_resume");

      sys = 1;
      step("syscall2");
      sys = 0;
      step("d2_drain1");
      mreq = 1;
      step("d2_memstall1");
      step("d2_memstall2");
      mreq = 0;
      step("d2_drain2");
      step("d2_drain3");
      step("d2_halt");
      en = 0;
      step("halt_disabled");
      en = 1;
      nRst = 0;
      check("reset_in_halt");
      @(posedge clk); #1;
      nRst = 1;
      res = 1;
      step("resume_ignored_run");
      idle();

      loaduse_x5();
      step("perf_lu1");
      idle();
      step("perf_gap");
      loaduse_x5();
      step("perf_lu2");
      idle(); br = 1;
      step("perf_br");
      idle();
      step("perf_end");

      for (int i = 0; i < 3000; i++) begin
         en   = ($urandom_range(0, 15) != 0);
         rs1  = AW'($urandom_range(0, 3));
         rs2  = AW'($urandom_range(0, 3));
         rd   = AW'($urandom_range(0, 3));
         exv  = $urandom_range(0, 1) == 1;
         exld = $urandom_range(0, 1) == 1;
         br   = $urandom_range(0, 3) == 0;
         jmp  = $urandom_range(0, 5) == 0;
         sys  = $urandom_range(0, 7) == 0;
         mreq = $urandom_range(0, 3) == 0;
         mack = $urandom_range(0, 1) == 1;
         res  = $urandom_range(0, 3) == 0;
         nRst = ($urandom_range(0, 199) != 0);
         step("random");
         nRst = 1;
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, fails);
      $finish;
   end

endmodule
